// File: rtl/predict_sched_if.sv
// Predictor table controller bundle: IF lookup, EX update and table RAM port.
interface predict_sched_if #(parameter int IDX_W = 7);
  logic              lookup_req;
  logic [31:0]       lookup_pc;
  logic [31:0]       lookup_inst;
  logic              lookup_gnt;
  logic              lookup_valid;
  logic              lookup_taken;
  logic [31:0]       lookup_target;
  logic              flush;
  logic              upd_req;
  logic [31:0]       upd_pc;
  logic              upd_success;
  logic              upd_ready;
  logic              tbl_en;
  logic              tbl_we;
  logic [IDX_W+1:0]  tbl_idx;
  logic [1:0]        tbl_wdata;
  logic [1:0]        tbl_rdata;

  modport master (
    output lookup_req, lookup_pc, lookup_inst, flush,
           upd_req, upd_pc, upd_success, tbl_rdata,
    input  lookup_gnt, lookup_valid, lookup_taken, lookup_target,
           upd_ready, tbl_en, tbl_we, tbl_idx, tbl_wdata
  );

  modport slave (
    input  lookup_req, lookup_pc, lookup_inst, flush,
           upd_req, upd_pc, upd_success, tbl_rdata,
    output lookup_gnt, lookup_valid, lookup_taken, lookup_target,
           upd_ready, tbl_en, tbl_we, tbl_idx, tbl_wdata
  );
endinterface

// File: rtl/predict_sched.sv
// Arbitrates the single-port pattern table between IF lookups and queued EX
// read-modify-write updates; owns global history and forms the predicted PC.
module predict_sched #(
  parameter int IDX_W      = 7,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  predict_sched_if.slave bus
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, UPD_RD, UPD_WR} state_t;

  function automatic logic [1:0] sat_next(input logic [1:0] s, input logic succ);
    logic [1:0] r;
    case (s)
      2'b00:   r = succ ? 2'b00 : 2'b01;
      2'b01:   r = succ ? 2'b00 : 2'b10;
      2'b10:   r = succ ? 2'b11 : 2'b01;
      default: r = succ ? 2'b11 : 2'b10;
    endcase
    return r;
  endfunction

  state_t          state_q;
  logic [1:0]      ghist_q;
  logic [SW-1:0]   starve_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            resp_q;
  logic [31:0]     pc_q;
  logic [12:1]     imm_q;
  logic [IDX_W-1:0] q_idx_q  [QDEPTH];
  logic             q_succ_q [QDEPTH];

  logic             q_nempty, push, pop, starved, gnt, head_succ;
  logic [IDX_W-1:0] head_idx;
  logic [31:0]      resp_sum;
  logic             unused_bits;

  assign unused_bits = ^{bus.upd_pc[31:IDX_W], bus.lookup_inst[24:12], bus.lookup_inst[6:0]};

  assign q_nempty  = (count_q != '0);
  assign push      = bus.upd_req && bus.upd_ready;
  assign pop       = (state_q == UPD_WR);
  assign head_idx  = q_idx_q[rd_ptr_q];
  assign head_succ = q_succ_q[rd_ptr_q];
  assign starved   = q_nempty && (starve_q == SW'(STARVE_MAX));
  assign gnt       = (state_q == IDLE) && bus.lookup_req && !starved;

  assign bus.upd_ready  = (count_q < CW'(QDEPTH));
  assign bus.lookup_gnt = gnt;
  assign bus.tbl_en     = gnt || (state_q != IDLE);
  assign bus.tbl_we     = (state_q == UPD_WR);
  assign bus.tbl_idx    = gnt ? {ghist_q, bus.lookup_pc[IDX_W-1:0]} : {ghist_q, head_idx};
  assign bus.tbl_wdata  = bus.tbl_we ? sat_next(bus.tbl_rdata, head_succ) : 2'b00;

  // A response is killed by flush in either the grant or the response cycle.
  assign bus.lookup_valid  = resp_q && !bus.flush;
  assign bus.lookup_taken  = bus.lookup_valid && bus.tbl_rdata[1];
  assign resp_sum          = pc_q + (bus.tbl_rdata[1] ? {{19{imm_q[12]}}, imm_q, 1'b0} : 32'd4);
  assign bus.lookup_target = bus.lookup_valid ? resp_sum : 32'd0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx_q[wr_ptr_q]  <= bus.upd_pc[IDX_W-1:0];
      q_succ_q[wr_ptr_q] <= bus.upd_success;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      ghist_q  <= 2'b00;
      starve_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      resp_q   <= 1'b0;
      pc_q     <= 32'd0;
      imm_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;

      resp_q <= gnt && !bus.flush;
      if (gnt) begin
        pc_q  <= bus.lookup_pc;
        imm_q <= {bus.lookup_inst[31], bus.lookup_inst[7],
                  bus.lookup_inst[30:25], bus.lookup_inst[11:8]};
        starve_q <= q_nempty ? (starved ? starve_q : starve_q + 1'b1) : '0;
      end

      case (state_q)
        IDLE:    if (!gnt && q_nempty) state_q <= UPD_RD;
        UPD_RD:  state_q <= UPD_WR;
        UPD_WR: begin
          ghist_q  <= sat_next(ghist_q, head_succ);
          starve_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_predict_sched.sv
// Self-checking bench for predict_sched: vector table, scoreboarded responses
// and update writes, plus starvation, overflow, flush and mid-update reset cases.
module tb_predict_sched;
  localparam int IDX_W = 7;
  localparam int QD    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  predict_sched_if #(.IDX_W(IDX_W)) bus ();
  predict_sched #(.IDX_W(IDX_W), .QDEPTH(QD), .STARVE_MAX(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Table RAM model: 1-cycle read latency, preload/clear side port.
  logic [1:0] tbl_mem [512];
  logic       pl_en = 1'b0, mem_clr = 1'b0;
  logic [8:0] pl_idx = '0;
  logic [1:0] pl_val = '0;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) tbl_mem[i] <= 2'b00;
    end else if (pl_en) begin
      tbl_mem[pl_idx] <= pl_val;
    end else if (bus.tbl_en) begin
      if (bus.tbl_we) tbl_mem[bus.tbl_idx] <= bus.tbl_wdata;
      bus.tbl_rdata <= tbl_mem[bus.tbl_idx];
    end
  end

  int total = 0;
  int bad   = 0;

  typedef struct { logic taken; logic [31:0] target; } resp_t;
  typedef struct { logic [6:0] idx; logic succ; } upd_t;
  resp_t sbq[$];
  upd_t  mq[$];
  logic [1:0] ghist_m = 2'b00;
  bit mon_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] s, input logic succ);
    if (succ) return (s[1] ? 2'b11 : 2'b00);
    return (s == 2'b00) ? 2'b01 : (s == 2'b11) ? 2'b10 : ~s;
  endfunction

  function automatic logic [31:0] bimm(input logic [31:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // Monitor: response scoreboard, ready tracking, grant index and RMW write checks.
  always @(negedge clk) begin
    if (mon_on && rst) begin
      if (sbq.size() > 0) begin
        resp_t e;
        e = sbq.pop_front();
        if (bus.flush) chk("sb_flushed_valid", 32'(bus.lookup_valid), 32'd0);
        else begin
          chk("sb_valid", 32'(bus.lookup_valid), 32'd1);
          chk("sb_taken", 32'(bus.lookup_taken), 32'(e.taken));
          chk("sb_target", bus.lookup_target, e.target);
        end
      end else begin
        chk("sb_idle_valid", 32'(bus.lookup_valid), 32'd0);
      end
      chk("mon_upd_ready", 32'(bus.upd_ready), 32'(mq.size() < QD));
      if (bus.upd_req && mq.size() < QD) mq.push_back('{bus.upd_pc[6:0], bus.upd_success});
      if (bus.lookup_gnt) begin
        logic [8:0] ix;
        ix = {ghist_m, bus.lookup_pc[6:0]};
        chk("gnt_idx", 32'(bus.tbl_idx), 32'(ix));
        chk("gnt_read", 32'({bus.tbl_en, bus.tbl_we}), 32'd2);
        if (!bus.flush)
          sbq.push_back('{tbl_mem[ix][1],
                          bus.lookup_pc + (tbl_mem[ix][1] ? bimm(bus.lookup_inst) : 32'd4)});
      end
      if (bus.tbl_en && bus.tbl_we) begin
        if (mq.size() == 0) chk("write_without_update", 32'd1, 32'd0);
        else begin
          upd_t u;
          u = mq.pop_front();
          chk("wr_idx", 32'(bus.tbl_idx), 32'({ghist_m, u.idx}));
          chk("wr_data", 32'(bus.tbl_wdata), 32'(nxt(tbl_mem[{ghist_m, u.idx}], u.succ)));
          ghist_m = nxt(ghist_m, u.succ);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [8:0] idx, input logic [1:0] val);
    pl_en = 1'b1; pl_idx = idx; pl_val = val;
    cyc();
    pl_en = 1'b0;
  endtask

  task automatic wait_we(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.tbl_we) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
    cyc();
  endtask

  typedef struct {
    logic [31:0] pc; logic [31:0] inst; logic [1:0] ctr;
    logic taken; logic [31:0] target;
  } vec_t;
  vec_t vecs [7];

  initial begin
    int g, blk;
    bit seen;
    vecs[0] = '{32'h0000_0100, 32'h0000_0063, 2'b00, 1'b0, 32'h0000_0104};
    vecs[1] = '{32'h0000_0104, 32'h0000_0863, 2'b10, 1'b1, 32'h0000_0114};
    vecs[2] = '{32'h0000_0208, 32'hFE00_0EE3, 2'b11, 1'b1, 32'h0000_0204};
    vecs[3] = '{32'h0000_020C, 32'hFE00_0EE3, 2'b01, 1'b0, 32'h0000_0210};
    vecs[4] = '{32'h0000_0010, 32'h0000_00E3, 2'b10, 1'b1, 32'h0000_0810};
    vecs[5] = '{32'hFFFF_FFF4, 32'h0000_0863, 2'b11, 1'b1, 32'h0000_0004};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0063, 2'b00, 1'b0, 32'h0000_0000};

    bus.lookup_req = 0; bus.lookup_pc = 0; bus.lookup_inst = 0; bus.flush = 0;
    bus.upd_req = 0; bus.upd_pc = 0; bus.upd_success = 0;

    // Reset values
    mem_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 mem_clr = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(bus.lookup_valid), 32'd0);
    chk("rst_taken", 32'(bus.lookup_taken), 32'd0);
    chk("rst_target", bus.lookup_target, 32'd0);
    chk("rst_tbl_en", 32'(bus.tbl_en), 32'd0);
    chk("rst_tbl_we", 32'(bus.tbl_we), 32'd0);
    chk("rst_upd_ready", 32'(bus.upd_ready), 32'd1);
    cyc();
    rst = 1'b1;
    mon_on = 1'b1;
    cyc();

    // Vector table: single lookups at ghist 00
    for (int v = 0; v < 7; v++) begin
      preload({2'b00, vecs[v].pc[6:0]}, vecs[v].ctr);
      bus.lookup_req = 1; bus.lookup_pc = vecs[v].pc; bus.lookup_inst = vecs[v].inst;
      @(negedge clk);
      chk("vec_gnt", 32'(bus.lookup_gnt), 32'd1);
      chk("vec_idx", 32'(bus.tbl_idx), 32'({2'b00, vecs[v].pc[6:0]}));
      cyc();
      bus.lookup_req = 0;
      @(negedge clk);
      chk("vec_valid", 32'(bus.lookup_valid), 32'd1);
      chk("vec_taken", 32'(bus.lookup_taken), 32'(vecs[v].taken));
      chk("vec_target", bus.lookup_target, vecs[v].target);
      cyc();
    end

    // Idle-bus update: entry {00,04}=10, success -> 11, ghist stays 00
    bus.upd_req = 1; bus.upd_pc = 32'h104; bus.upd_success = 1;
    cyc();
    bus.upd_req = 0;
    @(negedge clk);
    chk("upd_idle_port", 32'(bus.tbl_en), 32'd0);
    cyc();
    @(negedge clk);
    chk("upd_rd_en_we", 32'({bus.tbl_en, bus.tbl_we}), 32'd2);
    chk("upd_rd_idx", 32'(bus.tbl_idx), 32'h004);
    cyc();
    @(negedge clk);
    chk("upd_wr_we", 32'(bus.tbl_we), 32'd1);
    chk("upd_wr_idx", 32'(bus.tbl_idx), 32'h004);
    chk("upd_wr_data", 32'(bus.tbl_wdata), 32'd3);
    cyc();

    // Starvation: continuous lookups with one queued update
    bus.lookup_req = 1; bus.lookup_pc = 32'h300; bus.lookup_inst = 32'h63;
    bus.upd_req = 1; bus.upd_pc = 32'h10C; bus.upd_success = 1;
    cyc();
    bus.upd_req = 0;
    g = 0; blk = 0; seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.lookup_gnt) g++;
      if (bus.tbl_en && !bus.lookup_gnt) blk++;
      if (bus.tbl_we) begin
        seen = 1;
        chk("starve_wdata", 32'(bus.tbl_wdata), 32'd0);
      end
      cyc();
    end
    chk("starve_write_seen", 32'(seen), 32'd1);
    chk("starve_grants", 32'(g), 32'd3);
    chk("starve_port_block", 32'(blk), 32'd2);
    @(negedge clk);
    chk("starve_resume", 32'(bus.lookup_gnt), 32'd1);
    cyc();
    bus.lookup_req = 0;
    cyc();

    // Failed prediction moves ghist 00 -> 01; entry {00,08}=11 -> 10
    bus.upd_req = 1; bus.upd_pc = 32'h108; bus.upd_success = 0;
    cyc();
    bus.upd_req = 0;
    wait_we("ghist_upd_write");
    bus.lookup_req = 1; bus.lookup_pc = 32'h108; bus.lookup_inst = 32'h63;
    @(negedge clk);
    chk("ghist_idx", 32'(bus.tbl_idx), 32'h088);
    cyc();

    // Overflow: five pushes while lookups hold the port
    for (int i = 0; i < 5; i++) begin
      bus.upd_req = 1; bus.upd_pc = 32'h40 + 32'(4 * i); bus.upd_success = i[0];
      bus.lookup_pc = 32'h500 + 32'(4 * i);
      @(negedge clk);
      chk("ovf_ready", 32'(bus.upd_ready), 32'(i < 4));
      cyc();
    end
    bus.upd_req = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.tbl_we) begin
        seen = 1;
        chk("ovf_full_at_pop", 32'(bus.upd_ready), 32'd0);
      end
      cyc();
    end
    chk("ovf_pop_seen", 32'(seen), 32'd1);
    @(negedge clk);
    chk("ovf_ready_rise", 32'(bus.upd_ready), 32'd1);
    cyc();
    bus.lookup_req = 0;
    seen = 0;
    for (int k = 0; k < 60 && !seen; k++) begin
      cyc();
      if (mq.size() == 0) seen = 1;
    end
    chk("ovf_drain", 32'(seen), 32'd1);
    repeat (2) cyc();

    // Flush in the response cycle, then in the grant cycle
    bus.lookup_req = 1; bus.lookup_pc = 32'h100;
    @(negedge clk);
    cyc();
    bus.lookup_req = 0; bus.flush = 1;
    @(negedge clk);
    chk("flush_resp_valid", 32'(bus.lookup_valid), 32'd0);
    chk("flush_resp_target", bus.lookup_target, 32'd0);
    cyc();
    bus.flush = 1; bus.lookup_req = 1;
    @(negedge clk);
    chk("flush_gnt_gnt", 32'(bus.lookup_gnt), 32'd1);
    cyc();
    bus.flush = 0; bus.lookup_req = 0;
    @(negedge clk);
    chk("flush_gnt_valid", 32'(bus.lookup_valid), 32'd0);
    cyc();

    // Reset during UPD_RD: no write, queue cleared, ghist back to 00
    bus.upd_req = 1; bus.upd_pc = 32'h50; bus.upd_success = 0;
    cyc();
    bus.upd_req = 0;
    wait_we("pre_rst_write");
    bus.upd_req = 1; bus.upd_pc = 32'h54; bus.upd_success = 1;
    cyc();
    bus.upd_req = 0;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.tbl_en && !bus.tbl_we && !bus.lookup_gnt) seen = 1;
      else cyc();
    end
    chk("rst_found_upd_rd", 32'(seen), 32'd1);
    #1;
    mon_on = 0;
    rst = 1'b0;
    #1;
    chk("mid_rst_tbl_en", 32'(bus.tbl_en), 32'd0);
    chk("mid_rst_tbl_we", 32'(bus.tbl_we), 32'd0);
    chk("mid_rst_ready", 32'(bus.upd_ready), 32'd1);
    mq.delete(); sbq.delete(); ghist_m = 2'b00;
    @(negedge clk);
    chk("mid_rst_hold_we", 32'(bus.tbl_we), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    mon_on = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_queue_empty", 32'(bus.tbl_en), 32'd0);
      cyc();
    end
    bus.lookup_req = 1; bus.lookup_pc = 32'h1A4; bus.lookup_inst = 32'h63;
    @(negedge clk);
    chk("post_rst_ghist_idx", 32'(bus.tbl_idx), 32'h024);
    cyc();
    bus.lookup_req = 0;
    repeat (3) cyc();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
